normalizer_stream_arbiter: RTL and testbench
============================================

// Module: normalizer_stream_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that shares one data_normalizer datapath among NUM_STREAMS ndata_i producers.
//  Grants one stream at a time and holds the grant until that stream's last beat is accepted, so packets never interleave
//  (the normalizer's offset/flush logic relies on this). Forwards beats through a registered 2-entry skid slice
//  and tags each output beat with the source stream id.
// PARAMETERS
//  data_t        -            element type carried by ndata_i
//  NUM_ELEMENTS  8            elements per beat (keep width)
//  NUM_STREAMS   4            number of requesters, >= 1
//  ID_WIDTH      derived      NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1
// PORTS
//  clk            in   1                              clock, all logic on posedge
//  rst            in   1                              asynchronous, active-high reset
//  in[NUM_STREAMS] ndata_i.s #(data_t,NUM_ELEMENTS)   requester streams (data/keep/last/valid/ready)
//  out            ndata_i.m #(data_t,NUM_ELEMENTS)    to data_normalizer input
//  out_stream_id  out  ID_WIDTH                       source stream of current out beat, valid with out.valid
//  pkt_done       out  1                              1-cycle pulse when a last beat is accepted from the granted input
//  busy           out  1                              1 while state == LOCKED
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant=0, slice empty, out.valid=0, out.keep=0, out.last=0,
//   out_stream_id=0, pkt_done=0, busy=0, all in[i].ready=0. Reset mid-packet drops buffered beats; the packet is lost.
//  FSM IDLE:
//   - All in[i].ready=0.
//   - If any in[i].valid: grant <= first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_STREAMS; go to LOCKED.
//   - Otherwise stay in IDLE.
//   - Costs exactly 1 bubble cycle per packet.
//  FSM LOCKED:
//   - in[grant].ready = slice_can_accept; in[j!=grant].ready=0.
//   - Handshake = in[grant].valid && in[grant].ready.
//   - On a handshake with last=1: pkt_done=1 next cycle, rr_ptr <= (grant==NUM_STREAMS-1) ? 0 : grant+1, go to IDLE.
//   - Valid on non-granted streams is ignored; their beats stay in place.
//  Beats are forwarded unmodified, including keep==0 beats and last beats with partial keep; the arbiter never compacts.
//  Skid slice (2 entries):
//   - Latency: 1 cycle from input handshake to out.valid.
//   - Full throughput: 1 beat/cycle sustained while out.ready=1.
//   - slice_can_accept is registered (entry count <= 1), so in.ready has no combinational path from out.ready.
//   - While out.valid && !out.ready, out.data/keep/last/out_stream_id are held stable.
//  Simultaneous events:
//   - Grant release and the next arbitration never overlap: the last beat's cycle is followed by one IDLE cycle.
//   - A stream asserting valid in the same IDLE cycle as a higher-priority stream waits for the next round.
//  Fairness: a stream with continuous valid is granted within NUM_STREAMS packets.
//  NUM_STREAMS==1: rr_ptr is constant 0 and out_stream_id is constant 0; IDLE/LOCKED behaviour is unchanged.
//  No timeout: a granted stream that stalls mid-packet holds the datapath indefinitely (by design).
// STRUCTURE
//  Shared package (normalizer_pkg):
//   - typedef enum logic {IDLE, LOCKED} arb_state_t
//   - function next_rr(ptr, n) for the wrap-around increment
//  Sub-module ndata_skid_buffer #(data_t, NUM_ELEMENTS, SIDEBAND_WIDTH):
//   - 2-entry registered slice carrying data/keep/last plus sideband (stream id)
//   - Reusable ahead of the barrel shifter
//  Top level: FSM, round-robin search (rotate/priority/unrotate), input mux.
// TESTING
//  1. Reset: hold rst 3 cycles with in[0..3].valid=1 -> all ready=0, out.valid=0; first grant is stream 0,
//     one cycle after rst falls.
//  2. All 4 streams send continuous 3-beat packets, out.ready=1 -> output order 0,1,2,3,0,...; ids match;
//     no interleaving; 1 bubble per packet; pkt_done every 4 cycles.
//  3. Backpressure: out.ready toggles 1,0,0,1 during a 5-beat packet on stream 2 -> no beat lost or duplicated;
//     out fields stable while stalled.
//  4. Wrap-around: rr_ptr=3, only streams 1 and 3 valid -> grant 3, then 1, then 3.
//  5. Edge beats: single-beat packet (last=1, keep=8'h01), then beat with keep=0,last=0 -> both forwarded verbatim;
//     FSM back to IDLE after the first.
//  6. Async reset asserted mid-packet (beat 2 of 4, slice full) -> out.valid drops immediately; after release,
//     arbitration restarts from stream 0.

Source files
------------

// File: rtl/normalizer_pkg.sv
// Shared types and helpers for the data_normalizer front end.
package normalizer_pkg;

  // Arbiter FSM: IDLE arbitrates, LOCKED owns the datapath for one packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Round-robin pointer increment with wrap-around at n.
  function automatic int next_rr(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ndata_skid_buffer.sv
// Two-entry registered slice for ndata beats (data/keep/last) plus a sideband tag.
// Output comes straight from a register. s_ready is itself a register, so nothing
// on the upstream side depends combinationally on m_ready.
module ndata_skid_buffer #(
  parameter int ELEM_WIDTH     = 8,
  parameter int NUM_ELEMENTS   = 8,
  parameter int SIDEBAND_WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ELEM_WIDTH*NUM_ELEMENTS-1:0] s_data,
  input  logic [NUM_ELEMENTS-1:0]            s_keep,
  input  logic                               s_last,
  input  logic [SIDEBAND_WIDTH-1:0]          s_side,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [ELEM_WIDTH*NUM_ELEMENTS-1:0] m_data,
  output logic [NUM_ELEMENTS-1:0]            m_keep,
  output logic                               m_last,
  output logic [SIDEBAND_WIDTH-1:0]          m_side,
  output logic                               m_valid,
  input  logic                               m_ready
);

  typedef struct packed {
    logic [SIDEBAND_WIDTH-1:0]          side;
    logic [ELEM_WIDTH*NUM_ELEMENTS-1:0] data;
    logic [NUM_ELEMENTS-1:0]            keep;
    logic                               last;
  } entry_t;

  entry_t     in_entry;
  entry_t     head_q, head_d;   // entry presented on m_*
  entry_t     tail_q, tail_d;   // overflow entry, used only while m_ready stalls
  logic [1:0] count_q, count_d;
  logic       ready_q;
  logic       push, pop;

  assign in_entry = {s_side, s_data, s_keep, s_last};
  assign push     = s_valid && ready_q;
  assign pop      = (count_q != 2'd0) && m_ready;

  // Next occupancy and entry contents for every push/pop combination.
  always_comb begin
    // NOTE: every signal this block drives gets a default first, so the paths that leave an entry untouched cannot infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11:   head_d = in_entry;
          2'b10: begin
            tail_d  = in_entry;
            count_d = 2'd2;
          end
          2'b01:   count_d = 2'd0;
          default: ;
        endcase
      end
      default: begin
        // Full: s_ready is low, so only a pop can happen.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  // Slice registers; ready is registered from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload registers are reset as well, because keep/last/sideband must read 0 straight out of reset; a deeper FIFO array would normally be left unreset.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

  assign s_ready = ready_q;
  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_q.data;
  assign m_keep  = head_q.keep;
  assign m_last  = head_q.last;
  assign m_side  = head_q.side;

endmodule

// File: rtl/normalizer_stream_arbiter.sv
// Packet-granular round-robin arbiter that shares one data_normalizer among
// NUM_STREAMS producers. A grant is held until the owner's last beat is accepted,
// so packets never interleave. Beats pass unmodified through a 2-entry skid slice
// and are tagged with their source stream id. The element type is carried as
// ELEM_WIDTH-bit elements, NUM_ELEMENTS per beat.
module normalizer_stream_arbiter
  import normalizer_pkg::*;
#(
  parameter int ELEM_WIDTH   = 8,
  parameter int NUM_ELEMENTS = 8,
  parameter int NUM_STREAMS  = 4,
  parameter int ID_WIDTH     = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [NUM_STREAMS-1:0][ELEM_WIDTH*NUM_ELEMENTS-1:0] in_data,
  input  logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0]            in_keep,
  input  logic [NUM_STREAMS-1:0]                              in_last,
  input  logic [NUM_STREAMS-1:0]                              in_valid,
  output logic [NUM_STREAMS-1:0]                              in_ready,
  output logic [ELEM_WIDTH*NUM_ELEMENTS-1:0]                  out_data,
  output logic [NUM_ELEMENTS-1:0]                             out_keep,
  output logic                                                out_last,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [ID_WIDTH-1:0]                                 out_stream_id,
  output logic                                                pkt_done,
  output logic                                                busy
);

  localparam int DATA_WIDTH = ELEM_WIDTH * NUM_ELEMENTS;

  arb_state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]      grant_q, grant_d;
  logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]      rr_winner;
  logic                     pkt_done_q, pkt_done_d;

  logic [2*NUM_STREAMS-1:0] valid_dbl;
  logic [NUM_STREAMS-1:0]   valid_rot;

  logic [DATA_WIDTH-1:0]    sel_data;
  logic [NUM_ELEMENTS-1:0]  sel_keep;
  logic                     sel_last;
  logic                     sel_valid;
  logic                     slice_ready;
  logic                     handshake;

  // Round-robin search: rotate so rr_ptr lands on bit 0, pick the lowest set bit, rotate the index back.
  always_comb begin
    int rot_idx;
    int win_idx;
    valid_dbl = {in_valid, in_valid};
    valid_rot = valid_dbl[rr_ptr_q +: NUM_STREAMS];
    rot_idx   = 0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid_rot[i]) rot_idx = i;
    end
    win_idx = rot_idx + int'(rr_ptr_q);
    if (win_idx >= NUM_STREAMS) win_idx = win_idx - NUM_STREAMS;
    rr_winner = ID_WIDTH'(win_idx);
  end

  // Input mux: only the granted stream reaches the slice, and only while LOCKED.
  assign sel_data  = in_data[grant_q];
  assign sel_keep  = in_keep[grant_q];
  assign sel_last  = in_last[grant_q];
  assign sel_valid = (state_q == LOCKED) && in_valid[grant_q];
  assign handshake = sel_valid && slice_ready;

  // Next-state, grant/pointer updates and per-stream ready.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_done_d = 1'b0;
    in_ready   = '0;
    case (state_q)
      IDLE: begin
        // One bubble per packet: nothing is accepted while arbitrating.
        if (|in_valid) begin
          grant_d = rr_winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        in_ready[grant_q] = slice_ready;
        if (handshake && sel_last) begin
          pkt_done_d = 1'b1;
          rr_ptr_d   = ID_WIDTH'(next_rr(int'(grant_q), NUM_STREAMS));
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, grant, round-robin pointer and the pkt_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  ndata_skid_buffer #(
    .ELEM_WIDTH     (ELEM_WIDTH),
    .NUM_ELEMENTS   (NUM_ELEMENTS),
    .SIDEBAND_WIDTH (ID_WIDTH)
  ) u_slice (
    .clk     (clk),
    .rst     (rst),
    .s_data  (sel_data),
    .s_keep  (sel_keep),
    .s_last  (sel_last),
    .s_side  (grant_q),
    .s_valid (sel_valid),
    .s_ready (slice_ready),
    .m_data  (out_data),
    .m_keep  (out_keep),
    .m_last  (out_last),
    .m_side  (out_stream_id),
    .m_valid (out_valid),
    .m_ready (out_ready)
  );

  assign pkt_done = pkt_done_q;
  assign busy     = (state_q == LOCKED);

endmodule

// File: tb/tb_normalizer_stream_arbiter.sv
// Self-checking bench for normalizer_stream_arbiter: a transaction-level model
// (arbitration rules, a 2-deep queue for the slice) checked every cycle, plus
// literal expectations on grant order, pulse spacing and edge-case beats.
module tb_normalizer_stream_arbiter;

  localparam int NS = 4;
  localparam int NE = 8;
  localparam int EW = 8;
  localparam int DW = NE * EW;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NE-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] id;
    beat_t         b;
  } obeat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NS-1:0][DW-1:0]  in_data;
  logic [NS-1:0][NE-1:0]  in_keep;
  logic [NS-1:0]          in_last;
  logic [NS-1:0]          in_valid;
  logic [NS-1:0]          in_ready;
  logic [DW-1:0]          out_data;
  logic [NE-1:0]          out_keep;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [IW-1:0]          out_stream_id;
  logic                   pkt_done;
  logic                   busy;

  normalizer_stream_arbiter #(
    .ELEM_WIDTH   (EW),
    .NUM_ELEMENTS (NE),
    .NUM_STREAMS  (NS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_keep       (in_keep),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_stream_id (out_stream_id),
    .pkt_done      (pkt_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int s, input int n);
    return {8'(s), 56'(n)};
  endfunction

  // Source side: per-stream beat queues, front beat presented, popped after acceptance.
  beat_t        src_q [NS][$];
  logic [NS-1:0] fire = '0;
  int           ready_mode = 0;   // 0: ready high, 1: ready low, 2: pattern 1,0,0,1
  int           pat_cnt = 0;

  task automatic add_beat(input int s, input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    src_q[s].push_back(b);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int s = 0; s < NS; s++) begin
      if (fire[s] && !rst && src_q[s].size() > 0) src_q[s].delete(0);
      if (src_q[s].size() > 0) begin
        in_valid[s] = 1'b1;
        in_data[s]  = src_q[s][0].data;
        in_keep[s]  = src_q[s][0].keep;
        in_last[s]  = src_q[s][0].last;
      end else begin
        in_valid[s] = 1'b0;
        in_data[s]  = '0;
        in_keep[s]  = '0;
        in_last[s]  = 1'b0;
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: begin
        out_ready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
        pat_cnt++;
      end
    endcase
  end

  // Behavioural model: owner/round-robin rules and a queue standing in for the slice.
  obeat_t        m_q [$];
  bit            m_locked = 0;
  int            m_owner  = 0;
  int            m_rr     = 0;
  bit            m_done   = 0;
  bit            stall_prev = 0;
  obeat_t        stall_val;
  obeat_t        out_log [$];
  int            done_ids [$];
  int            done_cyc [$];

  always @(negedge clk) begin
    logic [NS-1:0] exp_ready;
    obeat_t        cur;
    obeat_t        nb;
    bit            push;
    bit            pop;
    bit            found;
    int            idx;

    fire = in_valid & in_ready;
    cur.id     = out_stream_id;
    cur.b.data = out_data;
    cur.b.keep = out_keep;
    cur.b.last = out_last;

    if (rst) begin
      m_q.delete();
      m_locked   = 0;
      m_owner    = 0;
      m_rr       = 0;
      m_done     = 0;
      stall_prev = 0;
    end

    exp_ready = '0;
    if (m_locked && m_q.size() <= 1) exp_ready[m_owner] = 1'b1;
    check("in_ready", in_ready, exp_ready);
    check("busy", busy, m_locked);
    check("pkt_done", pkt_done, m_done);
    check("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("out_stream_id", out_stream_id, m_q[0].id);
      check("out_data", out_data, m_q[0].b.data);
      check("out_keep", out_keep, m_q[0].b.keep);
      check("out_last", out_last, m_q[0].b.last);
    end else if (rst) begin
      check("rst_out_keep", out_keep, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_id", out_stream_id, 0);
    end
    if (stall_prev) check("stall_stable", cur, stall_val);

    if (!rst) begin
      if (out_valid && out_ready) begin
        out_log.push_back(cur);
        if (out_last) done_ids.push_back(int'(out_stream_id));
      end
      if (pkt_done) done_cyc.push_back(cyc);

      pop  = (m_q.size() > 0) && out_ready;
      push = m_locked && in_valid[m_owner] && (m_q.size() <= 1);
      m_done     = push && in_last[m_owner];
      stall_prev = out_valid && !out_ready;
      stall_val  = cur;
      if (pop) m_q.delete(0);
      if (push) begin
        nb.id     = IW'(m_owner);
        nb.b.data = in_data[m_owner];
        nb.b.keep = in_keep[m_owner];
        nb.b.last = in_last[m_owner];
        m_q.push_back(nb);
      end
      if (!m_locked) begin
        found = 0;
        for (int k = 0; k < NS; k++) begin
          idx = (m_rr + k) % NS;
          if (!found && in_valid[idx]) begin
            found   = 1;
            m_owner = idx;
          end
        end
        if (found) m_locked = 1;
      end else if (m_done) begin
        m_rr     = (m_owner + 1) % NS;
        m_locked = 0;
      end
    end
  end

  task automatic wait_quiet(input string name, input int max_cyc);
    bit ok;
    bit empty;
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      #1;
      empty = 1;
      for (int s = 0; s < NS; s++) if (src_q[s].size() != 0) empty = 0;
      ok = empty && (m_q.size() == 0) && !m_locked && !m_done;
    end
    check(name, ok, 1);
  endtask

  task automatic clear_logs();
    out_log.delete();
    done_ids.delete();
    done_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp2 [8];
    int exp4 [3];
    bit got;
    exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp4 = '{3, 1, 3};

    rst = 1'b1;
    in_data = '0; in_keep = '0; in_last = '0; in_valid = '0;
    out_ready = 1'b0;

    // Tests 1+2: every stream holds two 3-beat packets, valid already during reset.
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 3; b++)
          add_beat(s, mk(s, p * 3 + b), 8'hFF, b == 2);

    repeat (2) @(negedge clk);
    #1;
    check("t1_rst_ready", in_ready, 0);
    check("t1_rst_out_valid", out_valid, 0);
    check("t1_rst_busy", busy, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("t1_bubble_ready", in_ready, 0);
    @(negedge clk); #1;
    check("t1_first_grant", in_ready, 4'b0001);
    wait_quiet("t2_drain", 200);
    check("t2_pkt_count", done_ids.size(), 8);
    for (int i = 0; i < 8 && i < done_ids.size(); i++) check("t2_order", done_ids[i], exp2[i]);
    check("t2_pulse_count", done_cyc.size(), 8);
    for (int i = 1; i < done_cyc.size(); i++) check("t2_pulse_spacing", done_cyc[i] - done_cyc[i-1], 4);

    // Test 3: 5-beat packet on stream 2 under a 1,0,0,1 ready pattern.
    clear_logs();
    pat_cnt = 0;
    ready_mode = 2;
    for (int b = 0; b < 5; b++) add_beat(2, mk(2, 100 + b), 8'hFF, b == 4);
    wait_quiet("t3_drain", 100);
    check("t3_beat_count", out_log.size(), 5);
    for (int i = 0; i < out_log.size(); i++) begin
      check("t3_data", out_log[i].b.data, mk(2, 100 + i));
      check("t3_last", out_log[i].b.last, i == 4);
      check("t3_id", out_log[i].id, 2);
    end
    ready_mode = 0;

    // Test 4: pointer sits at 3; streams 3 (two packets) and 1 (one packet) contend.
    clear_logs();
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 2; b++) add_beat(3, mk(3, 200 + p * 2 + b), 8'hF0, b == 1);
    for (int b = 0; b < 2; b++) add_beat(1, mk(1, 300 + b), 8'h0F, b == 1);
    wait_quiet("t4_drain", 100);
    check("t4_pkt_count", done_ids.size(), 3);
    for (int i = 0; i < 3 && i < done_ids.size(); i++) check("t4_order", done_ids[i], exp4[i]);

    // Test 5: single-beat packet, then a keep==0 non-last beat, then a closing beat.
    clear_logs();
    add_beat(0, 64'h1122_3344_5566_7788, 8'h01, 1'b1);
    add_beat(0, 64'hA5A5_0000_FFFF_5A5A, 8'h00, 1'b0);
    add_beat(0, 64'h0000_0000_0000_0042, 8'hFF, 1'b1);
    wait_quiet("t5_drain", 100);
    check("t5_beat_count", out_log.size(), 3);
    if (out_log.size() >= 2) begin
      check("t5_b0_data", out_log[0].b.data, 64'h1122_3344_5566_7788);
      check("t5_b0_keep", out_log[0].b.keep, 8'h01);
      check("t5_b0_last", out_log[0].b.last, 1);
      check("t5_b1_data", out_log[1].b.data, 64'hA5A5_0000_FFFF_5A5A);
      check("t5_b1_keep", out_log[1].b.keep, 8'h00);
      check("t5_b1_last", out_log[1].b.last, 0);
    end
    check("t5_pulse_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("t5_pulse_spacing", done_cyc[1] - done_cyc[0], 3);

    // Test 6: stall a 4-beat packet on stream 1 until the slice is full, then reset.
    clear_logs();
    ready_mode = 1;
    for (int b = 0; b < 4; b++) add_beat(1, mk(1, 400 + b), 8'hFF, b == 3);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      got = (m_q.size() == 2);
    end
    check("t6_fill", got, 1);
    @(posedge clk);
    #3;
    check("t6_valid_before_rst", out_valid, 1);
    check("t6_ready_full", in_ready, 0);
    rst = 1'b1;
    for (int s = 0; s < NS; s++) src_q[s].delete();
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_keep", out_keep, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    clear_logs();
    ready_mode = 0;
    add_beat(2, mk(2, 500), 8'hFF, 1'b1);
    add_beat(0, mk(0, 501), 8'hFF, 1'b1);
    wait_quiet("t6_drain", 100);
    check("t6_pkt_count", done_ids.size(), 2);
    if (done_ids.size() == 2) begin
      check("t6_restart_first", done_ids[0], 0);
      check("t6_restart_second", done_ids[1], 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
